// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: stage-1 instruction register feeding an in-order result FIFO.
// Optional feature macro: IMM_GEN_CSR_UIMM_EN (enables the CSR uimm immediate for type 6).
module imm_gen_pipe #(
  parameter int XLEN       = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 5
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [31:0]                       in_inst,
  input  logic [2:0]                        in_type,
  input  logic [TAG_W-1:0]                  in_tag,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [XLEN-1:0]                   out_imm,
  output logic [TAG_W-1:0]                  out_tag,
  output logic                              out_illegal,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   occupancy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [2:0] T_U     = 3'd0;
  localparam logic [2:0] T_J     = 3'd1;
  localparam logic [2:0] T_I     = 3'd2;
  localparam logic [2:0] T_B     = 3'd3;
  localparam logic [2:0] T_S     = 3'd4;
  localparam logic [2:0] T_SHAMT = 3'd5;
  localparam logic [2:0] T_CSR   = 3'd6;

  // Every format fits in 32 bits; sext selects sign- versus zero-extension to XLEN.
  function automatic logic [XLEN:0] gen_imm(input logic [31:0] inst, input logic [2:0] typ);
    logic [31:0] v_s;
    logic        sext_s;
    logic        ill_s;
    logic [XLEN-1:0] imm_s;
    v_s    = 32'd0;
    sext_s = 1'b0;
    ill_s  = 1'b0;
    case (typ)
      T_U: begin
        v_s    = {inst[31:12], 12'd0};
        sext_s = 1'b1;
      end
      T_J: begin
        v_s    = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        sext_s = 1'b1;
      end
      T_I: begin
        v_s    = {{20{inst[31]}}, inst[31:20]};
        sext_s = 1'b1;
      end
      T_B: begin
        v_s    = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
        sext_s = 1'b1;
      end
      T_S: begin
        v_s    = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        sext_s = 1'b1;
      end
      T_SHAMT: begin
        if (XLEN == 32) begin
          if (inst[25]) begin
            ill_s = 1'b1;
          end else begin
            v_s = {27'd0, inst[24:20]};
          end
        end else begin
          v_s = {26'd0, inst[25:20]};
        end
      end
`ifdef IMM_GEN_CSR_UIMM_EN
      T_CSR: begin
        v_s = {27'd0, inst[19:15]};
      end
`else
      T_CSR: begin
        ill_s = 1'b1;
      end
`endif
      default: begin
        ill_s = 1'b1;
      end
    endcase
    if (sext_s) begin
      imm_s = XLEN'($signed(v_s));
    end else begin
      imm_s = XLEN'(v_s);
    end
    return {ill_s, imm_s};
  endfunction

  logic                  s1_valid_r;
  logic [31:0]           s1_inst_r;
  logic [2:0]            s1_type_r;
  logic [TAG_W-1:0]      s1_tag_r;

  logic [XLEN-1:0]       imm_mem_r [FIFO_DEPTH];
  logic [TAG_W-1:0]      tag_mem_r [FIFO_DEPTH];
  logic                  ill_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;

  logic                  head_valid_s;
  logic                  pop_raw_s;
  logic                  pop_s;
  logic                  advance_s;
  logic                  push_s;
  logic                  accept_s;
  logic [XLEN:0]         gen_s;

  // Handshake decode; a pop frees a slot in the same cycle so stage 1 may advance into a full FIFO.
  always_comb begin
    head_valid_s = (count_r != CNT_W'(0));
    pop_raw_s    = head_valid_s && out_ready;
    pop_s        = pop_raw_s && !flush;
    advance_s    = s1_valid_r && ((count_r < CNT_W'(FIFO_DEPTH)) || pop_raw_s);
    push_s       = advance_s && !flush;
    in_ready     = !flush && (!s1_valid_r || advance_s);
    accept_s     = in_valid && in_ready;
    gen_s        = gen_imm(s1_inst_r, s1_type_r);
  end

  // Stage-1 register: loads on accept, empties when its entry moves into the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_inst_r  <= 32'd0;
      s1_type_r  <= 3'd0;
      s1_tag_r   <= '0;
    end else if (flush) begin
      s1_valid_r <= 1'b0;
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_inst_r  <= in_inst;
      s1_type_r  <= in_type;
      s1_tag_r   <= in_tag;
    end else if (advance_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // FIFO storage; contents beyond the count are never observed, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      imm_mem_r[wr_ptr_r] <= gen_s[XLEN-1:0];
      tag_mem_r[wr_ptr_r] <= s1_tag_r;
      ill_mem_r[wr_ptr_r] <= gen_s[XLEN];
    end
  end

  // FIFO pointers and entry count; flush empties the queue outright.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Head presentation, forced to zero while the FIFO is empty.
  always_comb begin
    out_valid = head_valid_s;
    occupancy = count_r;
    if (head_valid_s) begin
      out_imm     = imm_mem_r[rd_ptr_r];
      out_tag     = tag_mem_r[rd_ptr_r];
      out_illegal = ill_mem_r[rd_ptr_r];
    end else begin
      out_imm     = '0;
      out_tag     = '0;
      out_illegal = 1'b0;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Randomized and directed bench for imm_gen_pipe; XLEN=64 and XLEN=32 instances share one stimulus stream.
module tb_imm_gen_pipe;

  localparam int D     = 4;
  localparam int TAG_W = 5;
`ifdef IMM_GEN_CSR_UIMM_EN
  localparam bit CSR_EN = 1'b1;
`else
  localparam bit CSR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, flush, in_valid, out_ready;
  logic [31:0] in_inst;
  logic [2:0] in_type;
  logic [TAG_W-1:0] in_tag;

  logic rdy64, ov64, ill64, rdy32, ov32, ill32;
  logic [63:0] imm64;
  logic [31:0] imm32;
  logic [TAG_W-1:0] tag64, tag32;
  logic [2:0] occ64, occ32;

  imm_gen_pipe #(.XLEN(64), .FIFO_DEPTH(D), .TAG_W(TAG_W)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_inst(in_inst), .in_type(in_type), .in_tag(in_tag), .out_valid(ov64),
    .out_ready(out_ready), .out_imm(imm64), .out_tag(tag64), .out_illegal(ill64),
    .occupancy(occ64));

  imm_gen_pipe #(.XLEN(32), .FIFO_DEPTH(D), .TAG_W(TAG_W)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_inst(in_inst), .in_type(in_type), .in_tag(in_tag), .out_valid(ov32),
    .out_ready(out_ready), .out_imm(imm32), .out_tag(tag32), .out_illegal(ill32),
    .occupancy(occ32));

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  typ;
    logic [TAG_W-1:0] tag;
  } ent_t;

  ent_t fifo_q[$];
  ent_t s1_e;
  bit   s1_v;
  bit   acc_last;
  int   total;
  int   bad;

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic longint unsigned sext(input longint unsigned x, input int n);
    longint s;
    s = $signed(x << (64 - n));
    s = s >>> (64 - n);
    return longint'(s);
  endfunction

  // Reference immediate: returns {illegal, imm} truncated to xlen bits.
  function automatic logic [64:0] ref_imm(input logic [31:0] inst, input logic [2:0] typ, input int xlen);
    longint unsigned v;
    bit ill;
    v = 0;
    ill = 1'b0;
    case (typ)
      3'd0: v = sext(longint'(inst[31:12]) * 4096, 32);
      3'd1: v = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}, 21);
      3'd2: v = sext(inst[31:20], 12);
      3'd3: v = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}, 13);
      3'd4: v = sext({inst[31:25], inst[11:7]}, 12);
      3'd5: begin
        if (xlen == 64) v = inst[25:20];
        else if (inst[25]) ill = 1'b1;
        else v = inst[24:20];
      end
      3'd6: begin
        if (CSR_EN) v = inst[19:15];
        else ill = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    if (xlen == 32) v = v % 64'h1_0000_0000;
    return {ill, v};
  endfunction

  // One clock: check outputs at the falling edge, advance the model, return 1ns after the rising edge.
  task automatic cycle();
    bit pop_m, adv_m, rdy_m;
    logic [64:0] h64, h32;
    logic [TAG_W-1:0] etag;
    @(negedge clk);
    pop_m = (fifo_q.size() > 0) && out_ready;
    adv_m = s1_v && ((fifo_q.size() < D) || pop_m);
    rdy_m = !flush && (!s1_v || adv_m);
    if (fifo_q.size() > 0) begin
      h64 = ref_imm(fifo_q[0].inst, fifo_q[0].typ, 64);
      h32 = ref_imm(fifo_q[0].inst, fifo_q[0].typ, 32);
      etag = fifo_q[0].tag;
    end else begin
      h64 = '0;
      h32 = '0;
      etag = '0;
    end
    check_val("in_ready64", rdy64, rdy_m);
    check_val("in_ready32", rdy32, rdy_m);
    check_val("out_valid64", ov64, fifo_q.size() > 0);
    check_val("out_valid32", ov32, fifo_q.size() > 0);
    check_val("occupancy", occ64, fifo_q.size());
    check_val("occupancy32", occ32, fifo_q.size());
    check_val("imm64", imm64, h64[63:0]);
    check_val("ill64", ill64, h64[64]);
    check_val("tag64", tag64, etag);
    check_val("imm32", imm32, h32[31:0]);
    check_val("ill32", ill32, h32[64]);
    check_val("tag32", tag32, etag);
    acc_last = in_valid && rdy_m && rst_n;
    if (!rst_n || flush) begin
      fifo_q.delete();
      s1_v = 1'b0;
    end else begin
      if (pop_m) void'(fifo_q.pop_front());
      if (adv_m) fifo_q.push_back(s1_e);
      if (acc_last) begin
        s1_e = '{inst: in_inst, typ: in_type, tag: in_tag};
        s1_v = 1'b1;
      end else if (adv_m) begin
        s1_v = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] inst, input logic [2:0] typ, input logic [TAG_W-1:0] tag);
    in_valid = 1'b1;
    in_inst = inst;
    in_type = typ;
    in_tag = tag;
    for (int n = 0; n < 50; n++) begin
      cycle();
      if (acc_last) break;
    end
    check_val("accepted", acc_last, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int n = 0; n < 20; n++) cycle();
    out_ready = 1'b0;
  endtask

  task automatic expect_head(input string name, input logic [63:0] e64, input logic e_ill64,
                             input logic [31:0] e32, input logic e_ill32, input logic [TAG_W-1:0] etag);
    check_val({name, "_valid"}, ov64, 1'b1);
    check_val({name, "_imm64"}, imm64, e64);
    check_val({name, "_ill64"}, ill64, e_ill64);
    check_val({name, "_tag"}, tag64, etag);
    check_val({name, "_imm32"}, imm32, e32);
    check_val({name, "_ill32"}, ill32, e_ill32);
  endtask

  initial begin
    total = 0;
    bad = 0;
    s1_v = 1'b0;
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_inst = 32'd0;
    in_type = 3'd0;
    in_tag = '0;
    repeat (3) cycle();
    rst_n = 1'b1;
    cycle();

    send(32'h800002B7, 3'd0, 5'd3);
    cycle();
    expect_head("u", 64'hFFFFFFFF80000000, 1'b0, 32'h80000000, 1'b0, 5'd3);
    drain();
    send(32'hFE000EE3, 3'd3, 5'd1);
    cycle();
    expect_head("b", 64'hFFFFFFFFFFFFFFFC, 1'b0, 32'hFFFFFFFC, 1'b0, 5'd1);
    drain();
    send(32'h0080006F, 3'd1, 5'd2);
    cycle();
    expect_head("j", 64'h8, 1'b0, 32'h8, 1'b0, 5'd2);
    drain();
    send(32'h01F01013, 3'd5, 5'd4);
    cycle();
    expect_head("shamt1f", 64'h1F, 1'b0, 32'h1F, 1'b0, 5'd4);
    drain();
    send(32'h03F01013, 3'd5, 5'd5);
    cycle();
    expect_head("shamt3f", 64'h3F, 1'b0, 32'h0, 1'b1, 5'd5);
    drain();
    send(32'h000F8073, 3'd6, 5'd6);
    cycle();
    if (CSR_EN) expect_head("csr", 64'h1F, 1'b0, 32'h1F, 1'b0, 5'd6);
    else expect_head("csr", 64'h0, 1'b1, 32'h0, 1'b1, 5'd6);
    drain();
    send(32'h000F8073, 3'd7, 5'd7);
    cycle();
    expect_head("type7", 64'h0, 1'b1, 32'h0, 1'b1, 5'd7);
    drain();

    // Backpressure: five fit, the sixth stalls until the consumer drains.
    for (int t = 0; t < 5; t++) send($urandom, 3'($urandom_range(0, 7)), 5'(t));
    check_val("bp_occ", occ64, 3'd4);
    in_valid = 1'b1;
    in_inst = $urandom;
    in_type = 3'd2;
    in_tag = 5'd5;
    cycle();
    check_val("bp_ready", rdy64, 1'b0);
    out_ready = 1'b1;
    for (int n = 0; n < 20 && !acc_last; n++) cycle();
    check_val("bp_accept6", acc_last, 1'b1);
    in_valid = 1'b0;
    drain();

    // Flush with three FIFO entries, stage 1 full and an input offered.
    for (int t = 10; t < 14; t++) send($urandom, 3'($urandom_range(0, 7)), 5'(t));
    in_valid = 1'b1;
    in_inst = $urandom;
    in_type = 3'd0;
    in_tag = 5'd20;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    check_val("flush_occ", occ64, 3'd0);
    check_val("flush_valid", ov64, 1'b0);
    drain();

    for (int n = 0; n < 800; n++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_inst = $urandom;
      in_type = 3'($urandom_range(0, 7));
      in_tag = 5'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 24) == 0);
      cycle();
    end
    in_valid = 1'b0;
    flush = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
